nios2_oci_dct_ctrl: RTL and testbench

Sequencer for the Nios II OCI data-capture-trace (DCT) path. Packs 2-bit trace items from the core into 30-bit DCT words, tracks the per-word item count, and hands complete words to the trace sink over a valid/ready handshake. On a test-ending request it runs a flush sequence and raises `test_has_ended`. It sits between the CPU trace tap and the OCI trace FIFO/test-bench monitor, and drives the `dct_buffer`/`dct_count`/`test_has_ended` signals that monitor consumes.

---
 rtl/nios2_oci_dct_ctrl_pkg.sv | 8 +
 rtl/nios2_oci_dct_pack.sv | 26 ++
 rtl/nios2_oci_dct_ctrl.sv | 91 +++++++++
 tb/tb_nios2_oci_dct_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_dct_ctrl_pkg.sv
// nios2_oci_dct_ctrl_pkg: shared widths and FSM states for the DCT trace sequencer.
package nios2_oci_dct_ctrl_pkg;
    localparam int DCT_ITEM_W = 2;
    localparam int DCT_ITEMS  = 15;
    localparam int DCT_BUF_W  = DCT_ITEMS * DCT_ITEM_W;
    localparam int DCT_CNT_W  = 4;
    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, ENDED} dct_state_t;
endpackage

// File: rtl/nios2_oci_dct_pack.sv
// nios2_oci_dct_pack: pack register; writes items to slot cnt, take empties it (a same-cycle item lands in slot 0).
module nios2_oci_dct_pack
    import nios2_oci_dct_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  take,
    input  logic [DCT_ITEM_W-1:0] wdata,
    output logic                  full,
    output logic [DCT_CNT_W-1:0]  cnt,
    output logic [DCT_BUF_W-1:0]  data
);
    assign full = cnt == DCT_CNT_W'(DCT_ITEMS);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            data <= '0;
            cnt  <= '0;
        end else if (take) begin
            data <= wr ? DCT_BUF_W'(wdata) : '0;
            cnt  <= wr ? DCT_CNT_W'(1) : '0;
        end else if (wr) begin
            data[{cnt, 1'b0} +: DCT_ITEM_W] <= wdata;
            cnt <= cnt + DCT_CNT_W'(1);
        end
endmodule

// File: rtl/nios2_oci_dct_ctrl.sv
// nios2_oci_dct_ctrl: packs trace items into DCT words, hands them out over valid/ready, flushes on test end.
// Define NIOS2_OCI_DCT_DROPCNT_EN to add the saturating dct_drop_count output.
module nios2_oci_dct_ctrl
    import nios2_oci_dct_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  item_valid,
    input  logic [DCT_ITEM_W-1:0] item_data,
    input  logic                  test_ending,
    output logic                  dct_valid,
    input  logic                  dct_ready,
    output logic [DCT_BUF_W-1:0]  dct_buffer,
    output logic [DCT_CNT_W-1:0]  dct_count,
    output logic                  dct_overflow,
`ifdef NIOS2_OCI_DCT_DROPCNT_EN
    output logic                  test_has_ended,
    output logic [7:0]            dct_drop_count
`else
    output logic                  test_has_ended
`endif
);
    dct_state_t state, state_nx;
    logic full, take, wr, drop, out_free;
    logic [DCT_CNT_W-1:0] pack_cnt;
    logic [DCT_BUF_W-1:0] pack_data;

    nios2_oci_dct_pack u_pack (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .take  (take),
        .wdata (item_data),
        .full  (full),
        .cnt   (pack_cnt),
        .data  (pack_data)
    );

    // The output slot can accept a word when empty or being popped this cycle.
    assign out_free = !dct_valid || dct_ready;

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        wr       = 1'b0;
        drop     = 1'b0;
        case (state)
            RUN: begin
                take     = full && out_free;
                wr       = item_valid && (!full || take);
                drop     = item_valid && full && !out_free;
                state_nx = test_ending ? FLUSH : RUN;
            end
            FLUSH: begin
                take     = pack_cnt != '0 && out_free;
                state_nx = (pack_cnt == '0 || out_free) ? DRAIN : FLUSH;
            end
            DRAIN:   state_nx = dct_valid ? DRAIN : ENDED;
            default: state_nx = ENDED;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state          <= RUN;
            dct_valid      <= 1'b0;
            dct_buffer     <= '0;
            dct_count      <= '0;
            dct_overflow   <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            state          <= state_nx;
            test_has_ended <= test_has_ended || state_nx == ENDED;
            dct_overflow   <= dct_overflow || drop;
            if (take) begin
                dct_valid  <= 1'b1;
                dct_buffer <= pack_data;
                dct_count  <= pack_cnt;
            end else if (dct_ready) begin
                dct_valid  <= 1'b0;
            end
        end

`ifdef NIOS2_OCI_DCT_DROPCNT_EN
    always_ff @(posedge clk or posedge reset)
        if (reset)
            dct_drop_count <= '0;
        else if (drop && dct_drop_count != 8'hff)
            dct_drop_count <= dct_drop_count + 8'd1;
`endif
endmodule

// File: tb/tb_nios2_oci_dct_ctrl.sv
// tb_nios2_oci_dct_ctrl: table of item runs plus hand sequences, words checked against a model-fed queue.
`timescale 1ns/1ps
module tb_nios2_oci_dct_ctrl;
    import nios2_oci_dct_ctrl_pkg::*;

    logic clk = 1'b0, reset = 1'b1, item_valid = 1'b0, test_ending = 1'b0, dct_ready = 1'b1;
    logic [1:0] item_data = '0;
    logic dct_valid, dct_overflow, test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0] dct_count;
`ifdef NIOS2_OCI_DCT_DROPCNT_EN
    logic [7:0] dct_drop_count;
`endif

    typedef struct packed {logic [29:0] data; logic [3:0] cnt;} word_t;
    typedef struct {int n; bit te; int words; int last_cnt; bit ended;} vec_t;

    word_t sb[$];
    logic [29:0] m_buf;
    int m_cnt, total = 0, bad = 0, pops = 0, last_seen = 0;
    vec_t tbl[6];

    nios2_oci_dct_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .item_valid     (item_valid),
        .item_data      (item_data),
        .test_ending    (test_ending),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_overflow   (dct_overflow),
`ifdef NIOS2_OCI_DCT_DROPCNT_EN
        .test_has_ended (test_has_ended),
        .dct_drop_count (dct_drop_count)
`else
        .test_has_ended (test_has_ended)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin : mon
        word_t w;
        if (!reset && dct_valid && dct_ready) begin
            pops++;
            last_seen = int'(dct_count);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h want none", dct_buffer);
            end else begin
                w = sb.pop_front();
                check("word_data", dct_buffer, w.data);
                check("word_cnt", dct_count, w.cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        item_valid = 1'b0;
        test_ending = 1'b0;
        dct_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        m_buf = '0;
        m_cnt = 0;
        sb.delete();
        pops = 0;
        last_seen = 0;
    endtask

    task automatic model_item(input logic [1:0] v);
        m_buf[2*m_cnt +: 2] = v;
        m_cnt++;
        if (m_cnt == 15) begin
            sb.push_back('{m_buf, 4'd15});
            m_buf = '0;
            m_cnt = 0;
        end
    endtask

    task automatic model_flush();
        if (m_cnt > 0) sb.push_back('{m_buf, 4'(m_cnt)});
        m_buf = '0;
        m_cnt = 0;
    endtask

    task automatic send(input logic [1:0] v, input bit te, input bit keep);
        item_valid = 1'b1;
        item_data = v;
        test_ending = te;
        step();
        item_valid = 1'b0;
        test_ending = 1'b0;
        if (keep) model_item(v);
        if (te) model_flush();
    endtask

    initial begin
        tbl[0] = '{15, 1'b0, 1, 15, 1'b0};
        tbl[1] = '{30, 1'b0, 2, 15, 1'b0};
        tbl[2] = '{6,  1'b1, 1, 6,  1'b1};
        tbl[3] = '{0,  1'b1, 0, 0,  1'b1};
        tbl[4] = '{20, 1'b1, 2, 5,  1'b1};
        tbl[5] = '{7,  1'b0, 0, 0,  1'b0};

        step();
        check("rst_valid", dct_valid, 0);
        check("rst_buffer", dct_buffer, 0);
        check("rst_count", dct_count, 0);
        check("rst_overflow", dct_overflow, 0);
        check("rst_ended", test_has_ended, 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int j = 0; j < tbl[i].n; j++)
                send(2'(j), tbl[i].te && j == tbl[i].n - 1, 1'b1);
            if (tbl[i].n == 0 && tbl[i].te) begin
                test_ending = 1'b1;
                step();
                test_ending = 1'b0;
                model_flush();
            end
            repeat (40) step();
            check("row_words", pops, tbl[i].words);
            check("row_last_cnt", last_seen, tbl[i].last_cnt);
            check("row_overflow", dct_overflow, 0);
            check("row_ended", test_has_ended, tbl[i].ended);
            check("row_sb_empty", sb.size(), 0);
        end

        // Reset mid-word (7 items still packed), then a fresh full word.
        reset = 1'b1;
        #1;
        check("mid_rst_valid", dct_valid, 0);
        check("mid_rst_buffer", dct_buffer, 0);
        check("mid_rst_count", dct_count, 0);
        do_reset();
        for (int j = 0; j < 15; j++) send(2'(3 - j), 1'b0, 1'b1);
        repeat (5) step();
        check("fresh_words", pops, 1);
        check("fresh_sb_empty", sb.size(), 0);

        // Latency: pack full one edge after item 15, word valid the next.
        do_reset();
        for (int j = 0; j < 15; j++) send(2'(j + 1), 1'b0, 1'b1);
        check("lat_not_yet", dct_valid, 0);
        step();
        check("lat_valid", dct_valid, 1);
        check("lat_count", dct_count, 15);
        check("lat_b10", dct_buffer[1:0], 2'd1);
        check("lat_b3_2", dct_buffer[3:2], 2'd2);
        check("lat_b29_28", dct_buffer[29:28], 2'd3);
        repeat (3) step();

        // End with a partial word: ended one edge after the pop, later items ignored.
        do_reset();
        for (int j = 0; j < 6; j++) send(2'(j), j == 5, 1'b1);
        step();
        check("end_word_valid", dct_valid, 1);
        check("end_word_cnt", dct_count, 6);
        check("end_not_yet", test_has_ended, 0);
        step();
        check("end_popped", dct_valid, 0);
        check("end_still_not", test_has_ended, 0);
        step();
        check("end_ended", test_has_ended, 1);
        for (int j = 0; j < 20; j++) send(2'(j), j == 3, 1'b0);
        repeat (3) step();
        check("end_ignored_pops", pops, 1);
        check("end_ignored_valid", dct_valid, 0);
        check("end_sticky", test_has_ended, 1);

        // End with nothing buffered: ended two edges after sampling, no valid pulse.
        do_reset();
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        check("empty_e0_valid", dct_valid, 0);
        check("empty_e0_ended", test_has_ended, 0);
        step();
        check("empty_e1_valid", dct_valid, 0);
        check("empty_e1_ended", test_has_ended, 0);
        step();
        check("empty_e2_ended", test_has_ended, 1);
        check("empty_pops", pops, 0);

        // Stalled sink: first word held, pack fills, item 31 dropped.
        do_reset();
        dct_ready = 1'b0;
        for (int j = 0; j < 31; j++) begin
            if (j == 30) check("ovf_before", dct_overflow, 0);
            send(2'(j + 2), 1'b0, j < 30);
            if (dct_valid) begin
                check("hold_data", dct_buffer, sb[0].data);
                check("hold_cnt", dct_count, sb[0].cnt);
            end
        end
        step();
        check("ovf_set", dct_overflow, 1);
        check("ovf_pending", sb.size(), 2);
`ifdef NIOS2_OCI_DCT_DROPCNT_EN
        check("drop_count", dct_drop_count, 1);
`endif
        dct_ready = 1'b1;
        repeat (6) step();
        check("ovf_drained", pops, 2);
        check("ovf_sb_empty", sb.size(), 0);
        check("ovf_sticky", dct_overflow, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
